// File: rtl/ops_queue.sv
// Operand-pair FIFO in front of the GCD unit: circular buffer with wrap-bit pointers.
// Optional same-cycle pass-through when empty is enabled by defining OPS_QUEUE_BYPASS_EN.
module ops_queue #(
  parameter int unsigned WL    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [WL-1:0] in_a,
  input  logic [WL-1:0] in_b,
  input  logic          in_val,
  output logic          in_rdy,
  output logic [WL-1:0] op_a,
  output logic [WL-1:0] op_b,
  output logic          ops_val,
  input  logic          ops_rdy,
  output logic [AW:0]   count
);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [WL-1:0] mem_a_q [DEPTH];
  logic [WL-1:0] mem_b_q [DEPTH];
  logic          empty, full, push, pop, bypass;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  // Gated by rst_b so the queue refuses pairs while held in reset.
  assign in_rdy = rst_b & ~full;
  assign count  = wr_ptr_q - rd_ptr_q;

`ifdef OPS_QUEUE_BYPASS_EN
  assign bypass = rst_b & empty & in_val & ops_rdy;

  always_comb begin
    ops_val = 1'b0;
    op_a    = '0;
    op_b    = '0;
    if (!empty) begin
      ops_val = 1'b1;
      op_a    = mem_a_q[rd_ptr_q[AW-1:0]];
      op_b    = mem_b_q[rd_ptr_q[AW-1:0]];
    end else if (rst_b && in_val) begin
      ops_val = 1'b1;
      op_a    = in_a;
      op_b    = in_b;
    end
  end
`else
  assign bypass = 1'b0;

  always_comb begin
    ops_val = 1'b0;
    op_a    = '0;
    op_b    = '0;
    if (!empty) begin
      ops_val = 1'b1;
      op_a    = mem_a_q[rd_ptr_q[AW-1:0]];
      op_b    = mem_b_q[rd_ptr_q[AW-1:0]];
    end
  end
`endif

  // A bypassed pair is consumed directly and never touches storage.
  assign push = in_val & in_rdy & ~bypass;
  assign pop  = ops_val & ops_rdy & ~empty;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q[AW-1:0]] <= in_a;
      mem_b_q[wr_ptr_q[AW-1:0]] <= in_b;
    end
  end

endmodule

// File: tb/tb_ops_queue.sv
// Bench for ops_queue: vector table for fill/drain, scoreboard queue for ordering,
// plus hand-written reset, streaming and empty-queue latency sequences.
module tb_ops_queue;

  localparam int unsigned WL    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
`ifdef OPS_QUEUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_b;
  logic [WL-1:0] in_a, in_b, op_a, op_b;
  logic          in_val, in_rdy, ops_val, ops_rdy;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;
  logic [15:0] sbq[$];

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       r;
    int         exp_cnt;
    logic       exp_rdy;
    int         exp_a;
  } vec_t;
  vec_t tbl[10];

  ops_queue #(.WL(WL), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_val (in_val),
    .in_rdy (in_rdy),
    .op_a   (op_a),
    .op_b   (op_b),
    .ops_val(ops_val),
    .ops_rdy(ops_rdy),
    .count  (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Drive inputs and check settled outputs against the scoreboard, before the edge.
  logic cur_v, cur_r;
  logic [7:0] cur_a, cur_b;
  task automatic apply(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
    logic exp_ov;
    logic [15:0] head;
    cur_v = v; cur_a = a; cur_b = b; cur_r = r;
    in_val = v; in_a = a; in_b = b; ops_rdy = r;
    #4;
    exp_ov = (sbq.size() != 0) || (Byp && v);
    chk("in_rdy", in_rdy, sbq.size() < DEPTH);
    chk("count", count, sbq.size());
    chk("ops_val", ops_val, exp_ov);
    head = (sbq.size() != 0) ? sbq[0] : {a, b};
    chk("op_a", op_a, exp_ov ? head[15:8] : 8'd0);
    chk("op_b", op_b, exp_ov ? head[7:0] : 8'd0);
  endtask

  // Update the model for the handshakes that happen at this edge, then advance.
  task automatic tick();
    logic byp_now, acc, popd;
    byp_now = Byp && (sbq.size() == 0) && cur_v && cur_r;
    acc     = cur_v && (sbq.size() < DEPTH) && !byp_now;
    popd    = (sbq.size() != 0) && cur_r;
    if (popd) void'(sbq.pop_front());
    if (acc) sbq.push_back({cur_a, cur_b});
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
    apply(v, a, b, r);
    tick();
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'd12,  8'd18, 1'b0, 0, 1'b1, Byp ? 12 : 0};
    tbl[1] = '{1'b1, 8'd7,   8'd21, 1'b0, 1, 1'b1, 12};
    tbl[2] = '{1'b1, 8'd9,   8'd6,  1'b0, 2, 1'b1, 12};
    tbl[3] = '{1'b1, 8'd100, 8'd75, 1'b0, 3, 1'b1, 12};
    tbl[4] = '{1'b1, 8'd5,   8'd5,  1'b0, 4, 1'b0, 12};
    tbl[5] = '{1'b0, 8'd0,   8'd0,  1'b1, 4, 1'b0, 12};
    tbl[6] = '{1'b0, 8'd0,   8'd0,  1'b1, 3, 1'b1, 7};
    tbl[7] = '{1'b0, 8'd0,   8'd0,  1'b1, 2, 1'b1, 9};
    tbl[8] = '{1'b0, 8'd0,   8'd0,  1'b1, 1, 1'b1, 100};
    tbl[9] = '{1'b0, 8'd0,   8'd0,  1'b0, 0, 1'b1, 0};

    // Reset held, even with a valid pair offered.
    rst_b = 1'b0; in_val = 1'b1; in_a = 8'd3; in_b = 8'd4; ops_rdy = 1'b1;
    #3;
    chk("rst_in_rdy", in_rdy, 1'b0);
    chk("rst_ops_val", ops_val, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_op_a", op_a, 0);
    in_val = 1'b0; ops_rdy = 1'b0;
    #4 rst_b = 1'b1;
    #1;
    chk("rel_in_rdy", in_rdy, 1'b1);
    chk("rel_ops_val", ops_val, 1'b0);
    chk("rel_count", count, 0);
    chk("rel_op_b", op_b, 0);
    @(posedge clk);
    #1;

    // Fill to full with the head held, refuse a fifth pair, then drain in order.
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].r);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_in_rdy", i), in_rdy, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_op_a", i), op_a, tbl[i].exp_a);
      tick();
    end

    // Streaming across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 8'(i + 1), 8'(2 * i + 3), 1'b1);
      if (i > 0) chk($sformatf("stream%0d_count", i), count, Byp ? 0 : 1);
      tick();
    end
    step(1'b0, 8'd0, 8'd0, 1'b1);
    chk("stream_drained", sbq.size(), 0);
    step(1'b0, 8'd0, 8'd0, 1'b0);

    // Asynchronous reset mid-operation discards stored pairs.
    step(1'b1, 8'd40, 8'd16, 1'b0);
    step(1'b1, 8'd2,  8'd4,  1'b0);
    step(1'b1, 8'd6,  8'd8,  1'b0);
    in_val = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_ops_val", ops_val, 1'b0);
    chk("mid_rst_count", count, 0);
    #2 rst_b = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    step(1'b1, 8'd40, 8'd16, 1'b0);
    step(1'b1, 8'd3,  8'd9,  1'b0);
    apply(1'b0, 8'd0, 8'd0, 1'b1);
    chk("post_rst_head_a", op_a, 40);
    chk("post_rst_head_b", op_b, 16);
    tick();
    step(1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 8'd0, 1'b0);

    // Empty-queue latency: same cycle with bypass, next cycle without.
    apply(1'b1, 8'd48, 8'd36, 1'b1);
    chk("lat_same_cycle", ops_val, Byp);
    tick();
    apply(1'b0, 8'd0, 8'd0, 1'b1);
    chk("lat_next_cycle", ops_val, !Byp);
    chk("lat_count", count, Byp ? 0 : 1);
    tick();
    step(1'b0, 8'd0, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
